// File: rtl/scan_cfg_pkg.sv
// ---------------------------------------------------------------------------
// scan_cfg_pkg
// Shared definitions for the scan-chain configuration loader.
//   state_e   : loader FSM state encoding
//   CRC_POLY  : CRC-16/CCITT generator polynomial
//   CRC_INIT  : CRC-16/CCITT initial value
//   crc16_step: one serial (1 bit) CRC update, MSB-first
// Used by scan_cfg_loader and scan_cfg_crc16 (the latter only when the
// build defines CFG_CRC_EN).
// ---------------------------------------------------------------------------
package scan_cfg_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_SHIFT = 3'd2,
        S_CRC   = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                               input logic        data_bit);
        logic w_fb;
        w_fb = crc[15] ^ data_bit;
        return {crc[14:0], 1'b0} ^ (w_fb ? CRC_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/scan_cfg_crc16.sv
// ---------------------------------------------------------------------------
// scan_cfg_crc16
// Serial CRC-16/CCITT accumulator, one bit per clock.
// Ports:
//   i_clk    in   clock
//   i_rst_n  in   asynchronous active-low reset (loads CRC_INIT)
//   i_clr    in   synchronous re-initialise to CRC_INIT (wins over i_en)
//   i_en     in   absorb i_bit on this edge
//   i_bit    in   serial data bit
//   o_crc    out  current CRC value
// ---------------------------------------------------------------------------
module scan_cfg_crc16
    import scan_cfg_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic        i_bit,
    output logic [15:0] o_crc
);

    logic [15:0] r_crc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_crc <= CRC_INIT;
        end else if (i_clr) begin
            r_crc <= CRC_INIT;
        end else if (i_en) begin
            r_crc <= crc16_step(r_crc, i_bit);
        end
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/scan_cfg_loader.sv
// ---------------------------------------------------------------------------
// scan_cfg_loader
// Serialises a host byte stream MSB-first onto the SRAM scan chain
// (scan_in / scan_en), shifting exactly total_bits bits, then reports done.
// Optional feature macro: CFG_CRC_EN -- when defined, a CRC-16/CCITT is
// accumulated over every shifted bit and checked against a 2-byte trailer
// (high byte first) taken through the host port after the last bit; a
// mismatch raises err in DONE. When undefined, err is tied to 0.
// Ports:
//   scan_clk    in   sole clock, shared with the chain
//   scan_rst_n  in   asynchronous active-low reset
//   start       in   begin a load (accepted in IDLE or DONE)
//   abort       in   synchronous return to IDLE (highest priority)
//   total_bits  in   chain length, sampled on start (0 = immediate finish)
//   din_valid   in   host byte valid
//   din         in   host byte, bit 7 shifted first
//   din_ready   out  byte accepted when din_valid && din_ready
//   scan_en     out  registered shift enable for the chain
//   scan_in     out  registered serial data bit
//   busy        out  high outside IDLE and DONE
//   done        out  high in DONE
//   err         out  CRC mismatch flag (CFG_CRC_EN only)
// ---------------------------------------------------------------------------
module scan_cfg_loader
    import scan_cfg_pkg::*;
#(
    parameter int unsigned CNT_W = 16
)
(
    input  logic             scan_clk,
    input  logic             scan_rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] total_bits,
    input  logic             din_valid,
    input  logic [7:0]       din,
    output logic             din_ready,
    output logic             scan_en,
    output logic             scan_in,
    output logic             busy,
    output logic             done,
    output logic             err
);

`ifdef CFG_CRC_EN
    localparam state_e END_STATE = S_CRC;
`else
    localparam state_e END_STATE = S_DONE;
`endif

    state_e           r_state;
    state_e           w_next;
    logic [CNT_W-1:0] r_bits_left;
    logic [3:0]       r_nbits;
    logic [7:0]       r_shreg;
    logic             r_scan_en;
    logic             r_scan_in;

    logic             w_start_ok;
    logic             w_hs;
    logic             w_byte_end;
    logic             w_last_bit;

`ifdef CFG_CRC_EN
    logic             r_crc_idx;
    logic [7:0]       r_crc_hi;
    logic             r_err;
    logic [15:0]      w_crc;
`endif

    assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    // abort outranks a handshake offered in the same cycle
    assign w_hs       = din_valid && din_ready && !abort;
    // nbits/bits_left are tested before their decrement on this edge
    assign w_byte_end = (r_nbits == 4'd1);
    assign w_last_bit = (r_bits_left == CNT_W'(1));

    // ---------------- state register ----------------
    always_ff @(posedge scan_clk or negedge scan_rst_n) begin
        if (!scan_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        w_next = (total_bits == '0) ? END_STATE : S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (w_hs) begin
                        w_next = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (w_byte_end) begin
                        w_next = w_last_bit ? END_STATE : S_FETCH;
                    end
                end
`ifdef CFG_CRC_EN
                S_CRC: begin
                    if (w_hs && r_crc_idx) begin
                        w_next = S_DONE;
                    end
                end
`endif
                default: w_next = S_IDLE;
            endcase
        end
    end

    // ---------------- state-decoded outputs ----------------
    always_comb begin
        din_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (r_state)
            S_FETCH: begin
                din_ready = 1'b1;
                busy      = 1'b1;
            end
            S_SHIFT: begin
                busy      = 1'b1;
            end
`ifdef CFG_CRC_EN
            S_CRC: begin
                din_ready = 1'b1;
                busy      = 1'b1;
            end
`endif
            S_DONE: begin
                done      = 1'b1;
            end
            default: ;
        endcase
    end

    // ---------------- shift datapath ----------------
    // scan_en/scan_in are registered from the SHIFT state, so each bit
    // reaches the chain one cycle after its SHIFT cycle.
    always_ff @(posedge scan_clk or negedge scan_rst_n) begin
        if (!scan_rst_n) begin
            r_bits_left <= '0;
            r_nbits     <= '0;
            r_shreg     <= '0;
            r_scan_en   <= 1'b0;
            r_scan_in   <= 1'b0;
        end else begin
            r_scan_en <= 1'b0;
            if (!abort) begin
                if (w_start_ok) begin
                    r_bits_left <= total_bits;
                end else if ((r_state == S_FETCH) && w_hs) begin
                    r_shreg <= din;
                    r_nbits <= (r_bits_left >= CNT_W'(8)) ? 4'd8 : r_bits_left[3:0];
                end else if (r_state == S_SHIFT) begin
                    r_scan_en   <= 1'b1;
                    r_scan_in   <= r_shreg[7];
                    r_shreg     <= {r_shreg[6:0], 1'b0};
                    r_nbits     <= r_nbits - 4'd1;
                    r_bits_left <= r_bits_left - CNT_W'(1);
                end
            end
        end
    end

    assign scan_en = r_scan_en;
    assign scan_in = r_scan_in;

`ifdef CFG_CRC_EN
    // The CRC sees exactly what the chain sees; the last bit is absorbed
    // one cycle after entering CRC, before the second trailer byte can land.
    scan_cfg_crc16 u_crc (
        .i_clk   (scan_clk),
        .i_rst_n (scan_rst_n),
        .i_clr   (w_start_ok && !abort),
        .i_en    (r_scan_en),
        .i_bit   (r_scan_in),
        .o_crc   (w_crc)
    );

    always_ff @(posedge scan_clk or negedge scan_rst_n) begin
        if (!scan_rst_n) begin
            r_crc_idx <= 1'b0;
            r_crc_hi  <= '0;
            r_err     <= 1'b0;
        end else if (abort || w_start_ok) begin
            r_crc_idx <= 1'b0;
            r_err     <= 1'b0;
        end else if ((r_state == S_CRC) && w_hs) begin
            if (!r_crc_idx) begin
                r_crc_hi  <= din;
                r_crc_idx <= 1'b1;
            end else begin
                r_err     <= ({r_crc_hi, din} != w_crc);
                r_crc_idx <= 1'b0;
            end
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule
